// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding, default operand width and divide-by-zero result constants.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;

    // Divide-by-zero result: every quotient bit is set, remainder is the raw dividend.
    localparam logic DZ_QUOT_BIT = 1'b1;
    // dz flag values: set when the completed operation had a zero divisor,
    // cleared by any completion with a non-zero divisor.
    localparam logic DZ_SET = 1'b1;
    localparam logic DZ_CLR = 1'b0;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep the
// difference when it does not go negative.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_part;
    logic [WIDTH:0] w_dsr;
    logic [WIDTH:0] w_diff;
    logic           w_unused_diff_msb;

    assign w_part = {i_rem, i_bit};
    assign w_dsr  = {1'b0, i_divisor};
    assign w_diff = w_part - w_dsr;

    // A restored remainder is always below the divisor, so the top bit of the
    // accepted difference is zero and never needs to be carried forward.
    assign w_unused_diff_msb = w_diff[WIDTH];

    assign o_qbit = (w_part >= w_dsr);
    assign o_rem  = o_qbit ? w_diff[WIDTH-1:0] : w_part[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for signed (DIV) and unsigned (DIVU)
// requests. Fixed WIDTH+1 cycle latency from acceptance to done.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int             CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nx;
    logic             w_accept;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_dividend;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz_op;

    logic [WIDTH-1:0] r_q_res;
    logic [WIDTH-1:0] r_r_res;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;

    logic [WIDTH-1:0] w_rem_nx;
    logic             w_qbit;

    // Magnitude of an operand: two's-complement absolute value in signed mode.
    // The most negative value maps to 2^(WIDTH-1), which fits unsigned.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic s);
        f_mag = (s && v[WIDTH-1]) ? -v : v;
    endfunction

    // Re-apply a sign to an unsigned magnitude result.
    function automatic logic [WIDTH-1:0] f_apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        f_apply_sign = neg ? -v : v;
    endfunction

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_quo[WIDTH-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_rem_nx),
        .o_qbit    (w_qbit)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nx;
    end

    // Next-state logic; abort wins over start and cancels RUN/FIX.
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_accept   = 1'b1;
                    w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort)                   w_state_nx = ST_IDLE;
                else if (r_cnt == LAST_STEP) w_state_nx = ST_FIX;
            end
            ST_FIX:  w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Control and result registers: step counter, busy/done, q/r/dz.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_q_res <= '0;
            r_r_res <= '0;
            r_dz    <= 1'b0;
        end else begin
            r_busy <= (w_state_nx != ST_IDLE);
            r_done <= (r_state == ST_FIX) && !abort;
            if (w_accept)               r_cnt <= '0;
            else if (r_state == ST_RUN) r_cnt <= r_cnt + CW'(1);
            if (r_state == ST_FIX && !abort) begin
                if (r_dz_op) begin
                    r_q_res <= {WIDTH{DZ_QUOT_BIT}};
                    r_r_res <= r_dividend;
                    r_dz    <= DZ_SET;
                end else begin
                    r_q_res <= f_apply_sign(r_quo, r_neg_q);
                    r_r_res <= f_apply_sign(r_rem, r_neg_r);
                    r_dz    <= DZ_CLR;
                end
            end
        end
    end

    // Datapath: latch operands on acceptance, one restoring step per RUN cycle.
    // r_quo starts as the dividend magnitude and is shifted left each step,
    // feeding dividend bits out of the top and quotient bits in at the bottom.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rem      <= '0;
            r_quo      <= f_mag(dividend, sign);
            r_dvs      <= f_mag(divisor, sign);
            r_dividend <= dividend;
            r_neg_q    <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_r    <= sign & dividend[WIDTH-1];
            r_dz_op    <= (divisor == '0);
        end else if (r_state == ST_RUN) begin
            r_rem <= w_rem_nx;
            r_quo <= {r_quo[WIDTH-2:0], w_qbit};
        end
    end

    assign q    = r_q_res;
    assign r    = r_r_res;
    assign busy = r_busy;
    assign done = r_done;
    assign dz   = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sign;
    logic        abort;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;
    logic        dz;

    int n_total = 0;
    int n_bad   = 0;

    // Last completed result as the model sees it.
    logic [31:0] m_q  = 32'h0;
    logic [31:0] m_r  = 32'h0;
    logic        m_dz = 1'b0;

    seq_divider #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sign     (sign),
        .abort    (abort),
        .dividend (dividend),
        .divisor  (divisor),
        .q        (q),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .dz       (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic division, truncating toward zero.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] eq, output logic [31:0] er, output logic ed);
        longint la, lb, lq, lr;
        if (b == 32'h0) begin
            eq = 32'hFFFF_FFFF;
            er = a;
            ed = 1'b1;
        end else begin
            if (s) begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
            end else begin
                la = longint'({32'h0, a});
                lb = longint'({32'h0, b});
            end
            lq = la / lb;
            lr = la % lb;
            eq = lq[31:0];
            er = lr[31:0];
            ed = 1'b0;
        end
    endtask

    // Issue one request from an idle cycle; returns in the done cycle so a
    // following call starts back-to-back. abort_at/poke_at count busy cycles.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int abort_at, input int poke_at);
        logic [31:0] eq, er;
        logic        ed;
        int          nbusy, guard, ndone;
        bit          aborted;
        ref_div(a, b, s, eq, er, ed);
        dividend = a;
        divisor  = b;
        sign     = s;
        start    = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        nbusy   = 0;
        guard   = 0;
        aborted = 0;
        while (!done && guard < 100) begin
            if (busy) nbusy++;
            start = 1'b0;
            if (poke_at > 0 && nbusy == poke_at) begin
                dividend = $urandom;
                divisor  = $urandom;
                sign     = ~s;
                start    = 1'b1;
            end
            if (abort_at > 0 && nbusy == abort_at) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                start = 1'b0;
                chk("abort_busy", 64'(busy), 64'h0);
                chk("abort_done", 64'(done), 64'h0);
                aborted = 1;
                break;
            end
            @(posedge clk); #1;
            guard++;
        end
        start = 1'b0;
        if (abort_at > 0) begin
            chk("abort_reached", 64'(aborted), 64'h1);
            ndone = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (done) ndone++;
            end
            chk("abort_nodone", 64'(ndone), 64'h0);
            chk("abort_keep_q", 64'(q), 64'(m_q));
            chk("abort_keep_r", 64'(r), 64'(m_r));
            chk("abort_keep_dz", 64'(dz), 64'(m_dz));
        end else begin
            chk("latency", 64'(nbusy), 64'd33);
            chk("q", 64'(q), 64'(eq));
            chk("r", 64'(r), 64'(er));
            chk("dz", 64'(dz), 64'(ed));
            chk("busy_low_at_done", 64'(busy), 64'h0);
            m_q  = eq;
            m_r  = er;
            m_dz = ed;
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          pick, ab, pk, n;

        rst      = 1'b1;
        start    = 1'b0;
        sign     = 1'b0;
        abort    = 1'b0;
        dividend = 32'h0;
        divisor  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", 64'(q), 64'h0);
        chk("rst_r", 64'(r), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_dz", 64'(dz), 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Unsigned 100/7 and a one-cycle done pulse.
        do_op(32'd100, 32'd7, 1'b0, 0, 0);
        chk("q_100_7", 64'(q), 64'd14);
        chk("r_100_7", 64'(r), 64'd2);
        @(posedge clk); #1;
        chk("done_pulse", 64'(done), 64'h0);

        // Abort at the 10th busy cycle keeps the previous result.
        do_op(32'd50, 32'd5, 1'b0, 10, 0);
        chk("abort_q14", 64'(q), 64'd14);
        chk("abort_r2", 64'(r), 64'd2);

        // Signed, then back-to-back with start in the done cycle.
        do_op(-32'sd7, 32'd2, 1'b1, 0, 0);
        chk("q_m7_2", 64'(q), 64'hFFFF_FFFD);
        chk("r_m7_2", 64'(r), 64'hFFFF_FFFF);
        do_op(32'd7, -32'sd2, 1'b1, 0, 0);
        chk("q_7_m2", 64'(q), 64'hFFFF_FFFD);
        chk("r_7_m2", 64'(r), 64'h1);
        @(posedge clk); #1;

        // Signed overflow and the same operands unsigned.
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
        chk("q_ovf", 64'(q), 64'h8000_0000);
        chk("r_ovf", 64'(r), 64'h0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0);
        chk("q_big_u", 64'(q), 64'h0);
        chk("r_big_u", 64'(r), 64'h8000_0000);

        // Divide by zero both modes, then a normal divide clears dz.
        do_op(32'h1234_5678, 32'h0, 1'b0, 0, 0);
        chk("dz_u", 64'(dz), 64'h1);
        do_op(32'h1234_5678, 32'h0, 1'b1, 0, 0);
        chk("dz_s_q", 64'(q), 64'hFFFF_FFFF);
        chk("dz_s_r", 64'(r), 64'h1234_5678);
        do_op(32'd9, 32'd3, 1'b0, 0, 0);
        chk("dz_clear", 64'(dz), 64'h0);
        chk("q_9_3", 64'(q), 64'd3);

        // A start pulse mid-RUN must not disturb the operation.
        do_op(32'd1000, 32'd3, 1'b0, 0, 12);
        chk("poke_q", 64'(q), 64'd333);
        @(posedge clk); #1;

        // start together with abort in IDLE is not accepted.
        dividend = 32'd21;
        divisor  = 32'd4;
        start    = 1'b1;
        abort    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 64'h0);
        @(posedge clk); #1;
        chk("start_abort_busy2", 64'(busy), 64'h0);
        chk("start_abort_done", 64'(done), 64'h0);

        // Randomized operations against the model.
        for (int i = 0; i < 40; i++) begin
            ra   = $urandom;
            pick = $urandom_range(0, 9);
            if (pick == 0)      rb = 32'h0;
            else if (pick < 4)  rb = 32'($urandom_range(1, 50));
            else if (pick == 4) rb = 32'hFFFF_FFFF;
            else                rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 33) : 0;
            pk = ($urandom_range(0, 5) == 0) ? $urandom_range(2, 30) : 0;
            do_op(ra, rb, rs, ab, pk);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        // Reset at the 5th busy cycle clears every output.
        @(posedge clk); #1;
        dividend = 32'd77;
        divisor  = 32'd5;
        sign     = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_q", 64'(q), 64'h0);
        chk("mrst_r", 64'(r), 64'h0);
        chk("mrst_busy", 64'(busy), 64'h0);
        chk("mrst_done", 64'(done), 64'h0);
        chk("mrst_dz", 64'(dz), 64'h0);
        m_q  = 32'h0;
        m_r  = 32'h0;
        m_dz = 1'b0;
        do_op(32'd77, 32'd5, 1'b0, 0, 0);
        chk("post_rst_q", 64'(q), 64'd15);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative radix-2 restoring divider that answers the MDU's `start`/`busy` divide request and returns quotient and remainder. Serves both DIV (signed) and DIVU (unsigned), selected per request. It sits under the MDU, which drives `start`, `sign` and `abort` and stalls the PC while `busy` is high. Fixed latency regardless of operand values.

## Interface
- `WIDTH`, 32, operand/result width in bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  request; accepted only when `busy`=0.
- `sign`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at acceptance.
- `abort`  in  1  cancel in-flight operation; synchronous.
- `dividend`  in  WIDTH  sampled at acceptance.
- `divisor`  in  WIDTH  sampled at acceptance.
- `q`  out  WIDTH  quotient; registered; holds until the next completion.
- `r`  out  WIDTH  remainder; registered; holds until the next completion.
- `busy`  out  1  high from the cycle after acceptance until completion.
- `done`  out  1  one-cycle pulse when `q`/`r` update.
- `dz`  out  1  divide-by-zero flag for the last completed operation.

## Operation
- States: IDLE, RUN, FIX.
  - IDLE: `start`=1 and `abort`=0 → latch operands, `sign`, and magnitudes (two's-complement absolute values when `sign`=1, raw values otherwise); clear the iteration counter; go to RUN.
  - RUN: one restoring step per cycle on the WIDTH-bit magnitudes, with a WIDTH+1-bit partial remainder. After WIDTH steps, go to FIX.
  - FIX: apply sign correction, register `q`/`r`/`dz`, pulse `done`, return to IDLE.
- Signed results:
  - Quotient truncates toward zero; it is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0, `dz`=0, with no special path. The 2^31 magnitude must fit the unsigned datapath.
- Divisor = 0 (either mode): full latency still applies; result q=all ones, r=dividend (raw), `dz`=1.
- `dz` is cleared on every non-zero-divisor completion.
- `start` while `busy`=1 is ignored; operands are not re-sampled.
- `abort`=1 in RUN or FIX → IDLE at the next edge; `busy`=0, no `done`, and `q`/`r`/`dz` keep their previous values.
- `abort` and `start` in the same IDLE cycle: `abort` wins and nothing is accepted.
- `start` in the cycle `done`=1 (`busy` already 0) is accepted, so back-to-back operations have no gap cycle.

## Timing
- Reset: state=IDLE, `q`=0, `r`=0, `busy`=0, `done`=0, `dz`=0, counter=0. `rst` mid-operation discards the operation and has the same effect at the next edge.
- Accept at edge E0. `busy`=1 after edges E0 through E_WIDTH (RUN lasts WIDTH cycles). FIX occupies the cycle after E_WIDTH.
- At edge E_(WIDTH+1): `q`/`r`/`dz` update, `busy`=0, `done`=1. `done`=0 after the next edge.
- With `busy` counted from acceptance, the total is WIDTH+1 cycles (33 for WIDTH=32).
- `busy` and `done` are registered outputs, with no combinational path from inputs.

## Structure
- The shared package holds:
  - the state encoding (IDLE/RUN/FIX);
  - the default WIDTH;
  - the divide-by-zero constants: all-ones quotient and the `dz` semantics.
- One sub-module is natural: `div_step`, a combinational single restoring step (partial remainder, divisor → next remainder, quotient bit). It is instantiated once in the RUN datapath.
- Counter width is clog2(WIDTH+1).

## Test plan
- Unsigned: `sign`=0, 100/7 → q=14, r=2, `dz`=0; `busy` high exactly 33 cycles; `done` high exactly 1 cycle.
- Signed: −7/2 → q=0xFFFFFFFD, r=0xFFFFFFFF. Then 7/−2 back-to-back (`start` in the `done` cycle) → q=0xFFFFFFFD, r=1.
- Signed overflow and unsigned large operands:
  - 0x80000000 / 0xFFFFFFFF signed → q=0x80000000, r=0.
  - The same operands unsigned → q=0, r=0x80000000.
- Divide by zero: 0x12345678 / 0 in both modes → q=0xFFFFFFFF, r=0x12345678, `dz`=1, same 33-cycle latency. A following 9/3 → q=3, r=0, `dz`=0.
- Abort and ignored start:
  - After the 100/7 result, start 50/5 and assert `abort` at the 10th `busy` cycle → `busy`=0 next edge, no `done`, q=14 and r=2 retained.
  - A `start` pulse mid-RUN with different operands has no effect on the result.
- Reset mid-RUN: `rst` at the 5th `busy` cycle → all outputs 0 after the edge. `start` with `abort` in the same cycle → not accepted.
